// File: rtl/keypad_entry.sv
// keypad_entry
//   Turns the keypad scanner's raw key code / is_pressed level into clean,
//   single press events. It builds a multi-digit BCD entry from those events
//   and converts the entry to binary when the enter key is pressed.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   key_code     in   [3:0] scanner decoded key value
//   is_pressed   in   scanner key-present level (toggles while a key is held)
//   key_valid    out  one-cycle pulse per accepted press
//   key_out      out  [3:0] code of the last accepted press
//   entry_bcd    out  [4*NUM_DIGITS-1:0] live entry buffer, LS digit in [3:0]
//   digit_count  out  [2:0] digits currently held in the buffer
//   busy         out  high while the BCD->binary conversion runs
//   value        out  [VALUE_W-1:0] binary value of the last entered number
//   value_valid  out  one-cycle pulse when value updates
module keypad_entry #(
  parameter int NUM_DIGITS      = 2,
  parameter int VALUE_W         = 7,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RELEASE_CYCLES  = 450000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              key_code,
  input  logic                    is_pressed,
  output logic                    key_valid,
  output logic [3:0]              key_out,
  output logic [4*NUM_DIGITS-1:0] entry_bcd,
  output logic [2:0]              digit_count,
  output logic                    busy,
  output logic [VALUE_W-1:0]      value,
  output logic                    value_valid
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int TMR_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] REL_LAST = TMR_W'(RELEASE_CYCLES - 1);
  localparam logic [2:0]       ND       = 3'(NUM_DIGITS);

  typedef enum logic [1:0] {P_IDLE, P_CONFIRM, P_HELD} press_e;
  typedef enum logic       {E_IDLE, E_CONVERT} entry_e;

  press_e               press_q, press_d;
  logic [3:0]           cand_q, cand_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 key_valid_q, key_valid_d;
  logic [3:0]           key_out_q, key_out_d;

  entry_e               ent_q, ent_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2:0]           step_q, step_d;
  logic [VALUE_W-1:0]   acc_q, acc_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic                 value_valid_q, value_valid_d;

  logic [2:0]           dig_idx;
  logic [3:0]           digit;

  // State register (both FSMs and their datapath)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q       <= P_IDLE;
      cand_q        <= '0;
      tmr_q         <= '0;
      key_valid_q   <= 1'b0;
      key_out_q     <= '0;
      ent_q         <= E_IDLE;
      bcd_q         <= '0;
      cnt_q         <= '0;
      step_q        <= '0;
      acc_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
    end else begin
      press_q       <= press_d;
      cand_q        <= cand_d;
      tmr_q         <= tmr_d;
      key_valid_q   <= key_valid_d;
      key_out_q     <= key_out_d;
      ent_q         <= ent_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      acc_q         <= acc_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
    end
  end

  // Next-state logic for both FSMs
  always_comb begin
    press_d = press_q;
    case (press_q)
      P_IDLE:    if (is_pressed) press_d = P_CONFIRM;
      P_CONFIRM: begin
        if (!is_pressed)                                  press_d = P_IDLE;
        else if (key_code == cand_q && tmr_q == DEB_LAST) press_d = P_HELD;
      end
      P_HELD:    if (!is_pressed && tmr_q == REL_LAST) press_d = P_IDLE;
      default:   press_d = P_IDLE;
    endcase

    ent_d = ent_q;
    case (ent_q)
      E_IDLE:    if (key_valid_q && key_out_q == 4'hA && cnt_q != 3'd0) ent_d = E_CONVERT;
      E_CONVERT: if (step_q == ND) ent_d = E_IDLE;
      default:   ent_d = E_IDLE;
    endcase
  end

  // Digit fed to the converter: most significant buffer position first
  always_comb begin
    dig_idx = ND - 3'd1 - step_q;
    digit   = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == 3'(i)) digit = bcd_q[4*i +: 4];
    end
  end

  // Output / datapath logic
  always_comb begin
    cand_d        = cand_q;
    tmr_d         = tmr_q;
    key_valid_d   = 1'b0;
    key_out_d     = key_out_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    acc_d         = acc_q;
    value_d       = value_q;
    value_valid_d = 1'b0;

    // One timer serves both the debounce window and the release window.
    case (press_q)
      P_IDLE: begin
        if (is_pressed) begin
          cand_d = key_code;
          tmr_d  = '0;
        end
      end
      P_CONFIRM: begin
        if (is_pressed) begin
          if (key_code != cand_q) begin
            cand_d = key_code;
            tmr_d  = '0;
          end else if (tmr_q == DEB_LAST) begin
            key_valid_d = 1'b1;
            key_out_d   = cand_q;
            tmr_d       = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      P_HELD: begin
        if (is_pressed)            tmr_d = '0;
        else if (tmr_q != REL_LAST) tmr_d = tmr_q + 1'b1;
        else                       tmr_d = '0;
      end
      default: tmr_d = '0;
    endcase

    // Key events are consumed only while not converting; others are dropped.
    case (ent_q)
      E_IDLE: begin
        if (key_valid_q) begin
          if (key_out_q <= 4'd9) begin
            if (cnt_q < ND) begin
              bcd_d = (bcd_q << 4) | BCD_W'(key_out_q);
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_out_q == 4'hB) begin
            if (cnt_q != 3'd0) begin
              bcd_d = bcd_q >> 4;
              cnt_d = cnt_q - 3'd1;
            end
          end else if (key_out_q == 4'hC) begin
            bcd_d = '0;
            cnt_d = '0;
          end else if (key_out_q == 4'hA) begin
            if (cnt_q != 3'd0) begin
              step_d = '0;
              acc_d  = '0;
            end
          end
        end
      end
      E_CONVERT: begin
        if (step_q != ND) begin
          // acc*10 + digit; the truncated sum equals the low VALUE_W bits
          // of the same computation carried out at VALUE_W+4 bits.
          acc_d  = (acc_q << 3) + (acc_q << 1) + VALUE_W'(digit);
          step_d = step_q + 3'd1;
        end else begin
          value_d       = acc_q;
          value_valid_d = 1'b1;
          bcd_d         = '0;
          cnt_d         = '0;
        end
      end
      default: ;
    endcase
  end

  assign key_valid   = key_valid_q;
  assign key_out     = key_out_q;
  assign entry_bcd   = bcd_q;
  assign digit_count = cnt_q;
  assign busy        = (ent_q == E_CONVERT);
  assign value       = value_q;
  assign value_valid = value_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

  localparam int ND  = 2;
  localparam int VW  = 7;
  localparam int DEB = 4;
  localparam int REL = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    key_code;
  logic          is_pressed;
  logic          key_valid;
  logic [3:0]    key_out;
  logic [4*ND-1:0] entry_bcd;
  logic [2:0]    digit_count;
  logic          busy;
  logic [VW-1:0] value;
  logic          value_valid;

  keypad_entry #(
    .NUM_DIGITS(ND), .VALUE_W(VW), .DEBOUNCE_CYCLES(DEB), .RELEASE_CYCLES(REL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .is_pressed(is_pressed),
    .key_valid(key_valid), .key_out(key_out), .entry_bcd(entry_bcd),
    .digit_count(digit_count), .busy(busy), .value(value), .value_valid(value_valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Event monitor, sampled on the falling edge
  int cyc = 0;
  int kv_cnt = 0, kv_cyc = 0, vv_cnt = 0, vv_lat = 0;
  logic [3:0]    kv_code = '0;
  logic [VW-1:0] vv_val  = '0;

  always @(negedge clk) begin
    cyc++;
    if (key_valid === 1'b1) begin
      kv_cnt++;
      kv_code = key_out;
      kv_cyc  = cyc;
    end
    if (value_valid === 1'b1) begin
      vv_cnt++;
      vv_val = value;
      vv_lat = cyc - kv_cyc;
    end
  end

  // Reference model: digits as a list, most significant first
  int q[$];
  int exp_value = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_bcd();
    int r = 0;
    foreach (q[i]) r = r * 16 + q[i];
    return r;
  endfunction

  task automatic model_key(input logic [3:0] k, output bit exp_vv);
    int v;
    exp_vv = 0;
    if (k <= 4'd9) begin
      if (q.size() < ND) q.push_back(int'(k));
    end else if (k == 4'hB) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if (k == 4'hC) begin
      q.delete();
    end else if (k == 4'hA && q.size() > 0) begin
      v = 0;
      foreach (q[i]) v = v * 10 + q[i];
      exp_value = v;
      exp_vv = 1;
      q.delete();
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic p, input int n);
    key_code   = c;
    is_pressed = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_entry(string tag);
    check({tag, "_bcd"}, 32'(entry_bcd), 32'(model_bcd()));
    check({tag, "_cnt"}, 32'(digit_count), 32'(q.size()));
  endtask

  // Clean press: stable code long enough to debounce, then a long release.
  // With scramble set, the code wanders after acceptance and must be ignored.
  task automatic press(input logic [3:0] k, input int hold, input int low, input bit scramble);
    int kv0, vv0;
    bit ev;
    kv0 = kv_cnt;
    vv0 = vv_cnt;
    drive(k, 1'b1, 6);
    for (int i = 6; i < hold; i++) drive(scramble ? 4'($urandom) : k, 1'b1, 1);
    drive(scramble ? 4'($urandom) : k, 1'b0, low);
    check("kv_count", 32'(kv_cnt), 32'(kv0 + 1));
    check("kv_code", 32'(kv_code), 32'(k));
    model_key(k, ev);
    check("vv_count", 32'(vv_cnt), 32'(vv0 + (ev ? 1 : 0)));
    check("value", 32'(value), 32'(exp_value));
    if (ev) begin
      check("vv_latency", 32'(vv_lat), 32'(ND + 2));
      check("vv_value", 32'(vv_val), 32'(exp_value));
    end
    check_entry("entry");
  endtask

  initial begin
    int kv0, vv0;
    bit seen;
    logic [3:0] keys[6];
    logic [7:0] exp_bcd[6];

    rst_n = 1'b0; key_code = '0; is_pressed = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_kv",  32'(key_valid), 0);
    check("rst_key", 32'(key_out), 0);
    check("rst_bcd", 32'(entry_bcd), 0);
    check("rst_cnt", 32'(digit_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_val", 32'(value), 0);
    check("rst_vv",  32'(value_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Long hold of key 7
    press(4'h7, 10, 20, 1'b0);
    check("t1_bcd", 32'(entry_bcd), 32'h07);
    press(4'hC, 6, 14, 1'b0);

    // Held key with an is_pressed level that keeps toggling
    kv0 = kv_cnt;
    repeat (4) begin
      drive(4'h3, 1'b1, 5);
      drive(4'h3, 1'b0, 8);
    end
    drive(4'h3, 1'b0, 20);
    check("held_kv_count", 32'(kv_cnt), 32'(kv0 + 1));
    check("held_kv_code", 32'(kv_code), 32'h3);
    begin bit ev; model_key(4'h3, ev); end
    check("held_cnt", 32'(digit_count), 1);
    check_entry("held");

    // Bounce that never stays stable long enough
    kv0 = kv_cnt;
    drive(4'h5, 1'b1, 2);
    drive(4'h5, 1'b0, 1);
    drive(4'h5, 1'b1, 2);
    drive(4'h5, 1'b0, 20);
    check("bounce_kv", 32'(kv_cnt), 32'(kv0));
    check_entry("bounce");

    // Digit entry, overflow, backspace and enter
    press(4'hC, 6, 14, 1'b0);
    keys    = '{4'h4, 4'h2, 4'h9, 4'hB, 4'h7, 4'hA};
    exp_bcd = '{8'h04, 8'h42, 8'h42, 8'h04, 8'h47, 8'h00};
    for (int i = 0; i < 6; i++) begin
      press(keys[i], 6, 14, 1'b0);
      check("seq_bcd", 32'(entry_bcd), 32'(exp_bcd[i]));
    end
    check("seq_value", 32'(value), 47);

    // Enter on an empty buffer
    vv0 = vv_cnt;
    press(4'hA, 6, 14, 1'b0);
    check("empty_enter_vv", 32'(vv_cnt), 32'(vv0));
    check("empty_enter_val", 32'(value), 47);
    press(4'h8, 6, 14, 1'b0);
    press(4'hC, 6, 14, 1'b0);
    check("clear_bcd", 32'(entry_bcd), 0);

    // Reset in the middle of a conversion
    press(4'h9, 6, 14, 1'b0);
    press(4'h9, 6, 14, 1'b0);
    key_code = 4'hA; is_pressed = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    check("busy_seen", 32'(seen), 1);
    rst_n = 1'b0; is_pressed = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_vv",   32'(value_valid), 0);
    check("mid_rst_val",  32'(value), 0);
    check("mid_rst_bcd",  32'(entry_bcd), 0);
    check("mid_rst_cnt",  32'(digit_count), 0);
    q.delete();
    exp_value = 0;
    drive(4'h0, 1'b0, 4);
    rst_n = 1'b1;
    drive(4'h0, 1'b0, 3);
    press(4'h9, 6, 14, 1'b0);
    press(4'h9, 6, 14, 1'b0);
    press(4'hA, 6, 14, 1'b0);
    check("after_rst_val", 32'(value), 99);

    // Random clean presses, code wandering while held
    repeat (40) begin
      press(4'($urandom_range(0, 15)), $urandom_range(6, 10), $urandom_range(13, 18), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
